// File: rtl/grid_io_param_if.sv
// Pad-ring and configuration-chain signal bundle for one grid_io_param tile.
// The tile connects through the slave modport; the fabric/test side uses master.
interface grid_io_param_if #(
    parameter int unsigned NUM_PADS = 5
);
    logic                ccff_head;
    logic                ccff_shift_en;
    logic                ccff_tail;
    logic                cfg_loaded;
    logic [NUM_PADS-1:0] fabric_outpad;
    logic [NUM_PADS-1:0] fabric_inpad;
    logic [NUM_PADS-1:0] pad_in;
    logic [NUM_PADS-1:0] pad_out;
    logic [NUM_PADS-1:0] pad_oe;

    modport master (
        output ccff_head, ccff_shift_en, fabric_outpad, pad_in,
        input  ccff_tail, cfg_loaded, fabric_inpad, pad_out, pad_oe
    );

    modport slave (
        input  ccff_head, ccff_shift_en, fabric_outpad, pad_in,
        output ccff_tail, cfg_loaded, fabric_inpad, pad_out, pad_oe
    );
endinterface

// File: rtl/grid_io_param.sv
// Parametrised perimeter I/O tile: NUM_PADS pads sharing one configuration-chain
// segment, held in a safe input/undriven state until a full burst is loaded.
module grid_io_param #(
    parameter int unsigned NUM_PADS = 5
) (
    input logic            prog_clk,
    input logic            prog_reset_n,
    grid_io_param_if.slave io
);
    localparam int unsigned CFG_BITS  = 4;
    localparam int unsigned CHAIN_LEN = NUM_PADS * CFG_BITS;
    localparam int unsigned CNT_W     = $clog2(CHAIN_LEN + 1);

    logic [CHAIN_LEN-1:0] cfg;
    logic [CNT_W-1:0]     count;
    logic                 shift_en_q;
    logic                 loaded;
    logic                 active;
    logic [NUM_PADS-1:0]  out_q;
    logic [NUM_PADS-1:0]  sync1;
    logic [NUM_PADS-1:0]  sync2;
    logic [NUM_PADS-1:0]  d;
    logic [NUM_PADS-1:0]  oe_f;
    logic [NUM_PADS-1:0]  inreg_f;
    logic [NUM_PADS-1:0]  outreg_f;
    logic [NUM_PADS-1:0]  inv_f;

    always_ff @(posedge prog_clk or negedge prog_reset_n) begin
        if (!prog_reset_n) begin
            cfg        <= '0;
            count      <= '0;
            shift_en_q <= 1'b0;
        end else begin
            shift_en_q <= io.ccff_shift_en;
            if (io.ccff_shift_en) begin
                cfg <= {cfg[CHAIN_LEN-2:0], io.ccff_head};
                // A rising shift_en restarts the count, so only an unbroken burst can load.
                if (!shift_en_q)
                    count <= CNT_W'(1);
                else if (count != CNT_W'(CHAIN_LEN))
                    count <= count + CNT_W'(1);
            end
        end
    end

    assign loaded        = (count == CNT_W'(CHAIN_LEN));
    assign active        = loaded & ~io.ccff_shift_en;
    assign io.cfg_loaded = loaded;
    assign io.ccff_tail  = cfg[CHAIN_LEN-1];

    always_comb begin
        oe_f     = '0;
        inreg_f  = '0;
        outreg_f = '0;
        inv_f    = '0;
        for (int unsigned p = 0; p < NUM_PADS; p++) begin
            oe_f[p]     = cfg[CFG_BITS*p + 0];
            inreg_f[p]  = cfg[CFG_BITS*p + 1];
            outreg_f[p] = cfg[CFG_BITS*p + 2];
            inv_f[p]    = cfg[CFG_BITS*p + 3];
        end
    end

    assign d = io.fabric_outpad ^ inv_f;

    // Synchronisers free-run so IN_REG pads are already settled when user mode starts.
    always_ff @(posedge prog_clk or negedge prog_reset_n) begin
        if (!prog_reset_n) begin
            out_q <= '0;
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= io.pad_in;
            sync2 <= sync1;
            if (active)
                out_q <= d;
        end
    end

    assign io.pad_out      = active ? ((outreg_f & out_q) | (~outreg_f & d)) : '0;
    assign io.pad_oe       = {NUM_PADS{active}} & oe_f;
    assign io.fabric_inpad = active ? (((inreg_f & sync2) | (~inreg_f & io.pad_in)) ^ inv_f) : '0;
endmodule

// File: tb/tb_grid_io_param.sv
// Directed self-checking bench for grid_io_param with NUM_PADS=5 (20-bit chain).
module tb_grid_io_param;
    logic clk;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;

    grid_io_param_if #(.NUM_PADS(5)) io ();

    grid_io_param #(.NUM_PADS(5)) dut (
        .prog_clk     (clk),
        .prog_reset_n (rst_n),
        .io           (io.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Shift the n least-significant bits of v, most significant first; shift_en stays high.
    task automatic shift_bits(input logic [39:0] v, input int n);
        for (int k = 0; k < n; k++) begin
            io.ccff_shift_en = 1'b1;
            io.ccff_head     = v[n-1-k];
            tick();
        end
    endtask

    logic [39:0] pat;
    logic [19:0] bs;

    initial begin
        rst_n            = 1'b0;
        io.ccff_head     = 1'b0;
        io.ccff_shift_en = 1'b0;
        io.fabric_outpad = '0;
        io.pad_in        = '0;
        #1;
        check("rst_loaded", io.cfg_loaded, 0);
        check("rst_tail", io.ccff_tail, 0);
        check("rst_oe", io.pad_oe, 0);
        check("rst_out", io.pad_out, 0);
        check("rst_in", io.fabric_inpad, 0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // Idle: pads stay safe regardless of data inputs
        io.pad_in        = 5'b11111;
        io.fabric_outpad = 5'b11111;
        tick();
        tick();
        #1;
        check("idle_in", io.fabric_inpad, 0);
        check("idle_out", io.pad_out, 0);
        check("idle_oe", io.pad_oe, 0);

        // pad0 = OE only
        io.fabric_outpad = '0;
        shift_bits(40'h00001 >> 1, 19);
        #1;
        check("b1_loaded19", io.cfg_loaded, 0);
        shift_bits(40'h1, 1);
        #1;
        check("b1_loaded20", io.cfg_loaded, 1);
        check("b1_oe_shifting", io.pad_oe, 0);
        io.ccff_shift_en = 1'b0;
        io.fabric_outpad = 5'b00001;
        #1;
        check("b1_out", io.pad_out, 5'b00001);
        check("b1_oe", io.pad_oe, 5'b00001);
        check("b1_in", io.fabric_inpad, 5'b11111);
        io.pad_in        = '0;
        io.fabric_outpad = '0;

        // pad2 = IN_REG | INV
        shift_bits(40'h00A00, 20);
        io.ccff_shift_en = 1'b0;
        #1;
        check("b2_in_idle", io.fabric_inpad, 5'b00100);
        io.pad_in = 5'b00100;
        #1;
        check("b2_in_0edge", io.fabric_inpad, 5'b00100);
        tick();
        #1;
        check("b2_in_1edge", io.fabric_inpad, 5'b00100);
        tick();
        #1;
        check("b2_in_2edge", io.fabric_inpad, 5'b00000);
        check("b2_oe", io.pad_oe, 0);

        // pad2 = OUT_REG; out_q[2] was left at 1 by the inverted zero above
        shift_bits(40'h00400, 20);
        io.ccff_shift_en = 1'b0;
        #1;
        check("b3_held", io.pad_out, 5'b00100);
        check("b3_in", io.fabric_inpad, 5'b00100);
        tick();
        #1;
        check("b3_follow0", io.pad_out, 5'b00000);
        io.fabric_outpad = 5'b00100;
        #1;
        check("b3_comb_hold", io.pad_out, 5'b00000);
        tick();
        #1;
        check("b3_follow1", io.pad_out, 5'b00100);

        // Raising shift_en in user mode forces safe outputs without a clock edge
        io.ccff_shift_en = 1'b1;
        #1;
        check("sh_out", io.pad_out, 0);
        check("sh_oe", io.pad_oe, 0);
        check("sh_in", io.fabric_inpad, 0);
        io.ccff_shift_en = 1'b0;
        #1;
        check("sh_back", io.pad_out, 5'b00100);
        tick();

        // 40-bit pass-through
        pat = 40'hA5A5A5A5A5;
        for (int j = 0; j < 40; j++) begin
            io.ccff_shift_en = 1'b1;
            io.ccff_head     = pat[39-j];
            #1;
            if (j >= 20)
                check($sformatf("tail_%0d", j), io.ccff_tail, pat[39-(j-20)]);
            tick();
        end
        #1;
        check("long_loaded", io.cfg_loaded, 1);
        io.ccff_shift_en = 1'b0;
        #1;
        check("long_oe", io.pad_oe, 5'b10101);
        tick();

        // Short burst of 19 bits
        shift_bits(40'h1, 1);
        #1;
        check("short_clear", io.cfg_loaded, 0);
        shift_bits(40'h0, 18);
        io.ccff_shift_en = 1'b0;
        #1;
        check("short_loaded", io.cfg_loaded, 0);
        check("short_oe", io.pad_oe, 0);
        check("short_out", io.pad_out, 0);
        check("short_in", io.fabric_inpad, 0);
        tick();
        shift_bits(40'h00001, 20);
        io.ccff_shift_en = 1'b0;
        #1;
        check("after_short_loaded", io.cfg_loaded, 1);
        check("after_short_oe", io.pad_oe, 5'b00001);
        tick();

        // Reset at burst cycle 10
        shift_bits(40'hFFFFF, 10);
        rst_n = 1'b0;
        #1;
        check("midrst_loaded", io.cfg_loaded, 0);
        check("midrst_tail", io.ccff_tail, 0);
        check("midrst_oe", io.pad_oe, 0);
        io.ccff_shift_en = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        bs = 20'h30005;
        shift_bits({20'h0, bs} >> 1, 19);
        #1;
        check("rb_loaded19", io.cfg_loaded, 0);
        shift_bits({39'h0, bs[0]}, 1);
        #1;
        check("rb_loaded20", io.cfg_loaded, 1);
        io.ccff_shift_en = 1'b0;
        #1;
        check("rb_oe", io.pad_oe, 5'b10001);
        io.ccff_shift_en = 1'b1;
        io.ccff_head     = 1'b0;
        for (int j = 0; j < 20; j++) begin
            #1;
            check($sformatf("rb_cfg_%0d", 19-j), io.ccff_tail, bs[19-j]);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
